// File: rtl/sar_avg_sequencer.sv
// sar_avg_sequencer: issues SOC pulses to a SAR FSM, averages 2**AVG_LOG2 captured results,
// and raises a sticky timeout flag when an EOC never arrives.
module sar_avg_sequencer #(
  parameter int WIDTH    = 7,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             eoc_i,
  input  logic [WIDTH-1:0] result_i,
  output logic             soc_o,
  output logic [WIDTH-1:0] avg_o,
  output logic             avg_valid_o,
  output logic             busy_o,
  output logic             timeout_o
);

  localparam int ACC_W = WIDTH + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [7:0]       TMR_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [WIDTH-1:0] avg_next;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       tmr;
  logic             eoc_q;
  logic             eoc_rise;

  assign eoc_rise = eoc_i & ~eoc_q;
  assign acc_sum  = acc + ACC_W'(result_i);
  assign avg_next = WIDTH'(acc_sum >> AVG_LOG2);

  // The average is published on the same edge that enters DONE, so avg_o and
  // avg_valid_o are both valid during the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      soc_o       <= 1'b0;
      avg_o       <= '0;
      avg_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      timeout_o   <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      tmr         <= '0;
      eoc_q       <= 1'b0;
    end else begin
      eoc_q       <= eoc_i;
      soc_o       <= 1'b0;
      avg_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start || en) begin
            timeout_o <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            state     <= REQ;
            soc_o     <= 1'b1;
            busy_o    <= 1'b1;
          end
        end
        REQ: begin
          tmr   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          tmr <= tmr + 8'd1;
          // A fresh EOC edge takes priority over an expiring timer.
          if (eoc_rise) begin
            acc <= acc_sum;
            if (cnt == CNT_LAST) begin
              state       <= DONE;
              avg_o       <= avg_next;
              avg_valid_o <= 1'b1;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= REQ;
              soc_o <= 1'b1;
            end
          end else if (tmr == TMR_LAST) begin
            timeout_o <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            state     <= IDLE;
            busy_o    <= 1'b0;
          end
        end
        DONE: begin
          acc <= '0;
          cnt <= '0;
          if (en) begin
            state <= REQ;
            soc_o <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
